// File: rtl/gelato_split_table_ctrl.sv
// Per-warp SIMT split-table (reconvergence stack) controller.
// Sequences SPLIT/JOIN commands into table updates and fetch redirects.
module gelato_split_table_ctrl #(
    parameter int WARP_NUM   = 8,
    parameter int THREAD_NUM = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 32,
    localparam int WW = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1,
    localparam int SW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WW-1:0]         lk_warp_num,
    output logic [THREAD_NUM-1:0] lk_thread_mask,
    output logic [SW-1:0]         lk_depth,
    input  logic                  init_valid,
    input  logic [WW-1:0]         init_warp_num,
    input  logic [ADDR_W-1:0]     init_pc,
    input  logic [THREAD_NUM-1:0] init_mask,
    output logic                  init_ready,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [WW-1:0]         cmd_warp_num,
    input  logic [THREAD_NUM-1:0] cmd_taken_mask,
    input  logic [ADDR_W-1:0]     cmd_taken_pc,
    input  logic [ADDR_W-1:0]     cmd_fall_pc,
    input  logic [ADDR_W-1:0]     cmd_reconv_pc,
    output logic                  redir_valid,
    output logic [WW-1:0]         redir_warp_num,
    output logic [ADDR_W-1:0]     redir_pc,
    output logic [THREAD_NUM-1:0] redir_mask,
    output logic                  overflow_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PUSH2 = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [THREAD_NUM-1:0] mask_q [WARP_NUM][DEPTH];
    logic [ADDR_W-1:0]     pc_q   [WARP_NUM][DEPTH];
    logic [ADDR_W-1:0]     rpc_q  [WARP_NUM][DEPTH];
    logic [SW-1:0]         sp_q   [WARP_NUM];

    logic [WW-1:0]         pend_warp_q;
    logic [THREAD_NUM-1:0] pend_mask_q;
    logic [ADDR_W-1:0]     pend_pc_q;
    logic [ADDR_W-1:0]     pend_rpc_q;

    logic                  redir_valid_q, redir_valid_d;
    logic [WW-1:0]         redir_warp_q, redir_warp_d;
    logic [ADDR_W-1:0]     redir_pc_q, redir_pc_d;
    logic [THREAD_NUM-1:0] redir_mask_q, redir_mask_d;
    logic                  ovf_q;

    logic                  init_fire, cmd_fire;
    logic [SW-1:0]         cmd_sp;
    logic [SW:0]           sp_plus2;
    logic [IW-1:0]         top_idx, nxt_idx;
    logic [THREAD_NUM-1:0] top_mask, taken_t;
    logic [ADDR_W-1:0]     top_rpc;

    logic                  init_go;
    logic                  tpc_we;
    logic [ADDR_W-1:0]     tpc_val;
    logic                  push_we;
    logic [WW-1:0]         push_warp;
    logic [IW-1:0]         push_idx;
    logic [THREAD_NUM-1:0] push_mask;
    logic [ADDR_W-1:0]     push_pc;
    logic [ADDR_W-1:0]     push_rpc;
    logic                  sp_we;
    logic [WW-1:0]         sp_warp;
    logic [SW-1:0]         sp_val;
    logic                  pend_we;
    logic                  ovf_set;

    assign init_ready = (state_q == IDLE) & ~rst;
    assign cmd_ready  = init_ready & ~init_valid;
    assign init_fire  = init_valid & init_ready;
    assign cmd_fire   = cmd_valid & cmd_ready;

    assign redir_valid    = redir_valid_q & ~rst;
    assign redir_warp_num = rst ? '0 : redir_warp_q;
    assign redir_pc       = rst ? '0 : redir_pc_q;
    assign redir_mask     = rst ? '0 : redir_mask_q;
    assign overflow_err   = ovf_q & ~rst;

    // Lookup sees committed state only, never the in-flight update.
    always_comb begin
        lk_depth       = sp_q[lk_warp_num];
        lk_thread_mask = '0;
        if (lk_depth != '0) begin
            lk_thread_mask = mask_q[lk_warp_num][IW'(lk_depth - SW'(1))];
        end
    end

    always_comb begin
        cmd_sp   = sp_q[cmd_warp_num];
        top_idx  = IW'(cmd_sp - SW'(1));
        nxt_idx  = IW'(cmd_sp - SW'(2));
        top_mask = mask_q[cmd_warp_num][top_idx];
        top_rpc  = rpc_q[cmd_warp_num][top_idx];
        taken_t  = cmd_taken_mask & top_mask;
        sp_plus2 = {1'b0, cmd_sp} + (SW+1)'(2);
    end

    always_comb begin
        state_d       = state_q;
        init_go       = 1'b0;
        tpc_we        = 1'b0;
        tpc_val       = '0;
        push_we       = 1'b0;
        push_warp     = '0;
        push_idx      = '0;
        push_mask     = '0;
        push_pc       = '0;
        push_rpc      = '0;
        sp_we         = 1'b0;
        sp_warp       = '0;
        sp_val        = '0;
        pend_we       = 1'b0;
        ovf_set       = 1'b0;
        redir_valid_d = 1'b0;
        redir_warp_d  = '0;
        redir_pc_d    = '0;
        redir_mask_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (init_fire) begin
                    init_go = 1'b1;
                end else if (cmd_fire && !cmd_op && cmd_sp != '0) begin
                    if (taken_t == '0) begin
                        tpc_we        = 1'b1;
                        tpc_val       = cmd_fall_pc;
                        redir_valid_d = 1'b1;
                        redir_warp_d  = cmd_warp_num;
                        redir_pc_d    = cmd_fall_pc;
                        redir_mask_d  = top_mask;
                    end else if (taken_t == top_mask) begin
                        tpc_we        = 1'b1;
                        tpc_val       = cmd_taken_pc;
                        redir_valid_d = 1'b1;
                        redir_warp_d  = cmd_warp_num;
                        redir_pc_d    = cmd_taken_pc;
                        redir_mask_d  = top_mask;
                    end else if (sp_plus2 > (SW+1)'(DEPTH)) begin
                        ovf_set = 1'b1;
                    end else begin
                        // Not-taken side goes under, taken side is pushed next cycle.
                        tpc_we    = 1'b1;
                        tpc_val   = cmd_reconv_pc;
                        push_we   = 1'b1;
                        push_warp = cmd_warp_num;
                        push_idx  = IW'(cmd_sp);
                        push_mask = top_mask & ~taken_t;
                        push_pc   = cmd_fall_pc;
                        push_rpc  = cmd_reconv_pc;
                        sp_we     = 1'b1;
                        sp_warp   = cmd_warp_num;
                        sp_val    = cmd_sp + SW'(1);
                        pend_we   = 1'b1;
                        state_d   = PUSH2;
                    end
                end else if (cmd_fire && cmd_op && cmd_sp > SW'(1)
                             && cmd_fall_pc == top_rpc) begin
                    sp_we         = 1'b1;
                    sp_warp       = cmd_warp_num;
                    sp_val        = cmd_sp - SW'(1);
                    redir_valid_d = 1'b1;
                    redir_warp_d  = cmd_warp_num;
                    redir_pc_d    = pc_q[cmd_warp_num][nxt_idx];
                    redir_mask_d  = mask_q[cmd_warp_num][nxt_idx];
                end
            end
            PUSH2: begin
                push_we       = 1'b1;
                push_warp     = pend_warp_q;
                push_idx      = IW'(sp_q[pend_warp_q]);
                push_mask     = pend_mask_q;
                push_pc       = pend_pc_q;
                push_rpc      = pend_rpc_q;
                sp_we         = 1'b1;
                sp_warp       = pend_warp_q;
                sp_val        = sp_q[pend_warp_q] + SW'(1);
                redir_valid_d = 1'b1;
                redir_warp_d  = pend_warp_q;
                redir_pc_d    = pend_pc_q;
                redir_mask_d  = pend_mask_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            for (int i = 0; i < WARP_NUM; i++) begin
                sp_q[i] <= '0;
            end
            ovf_q         <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_warp_q  <= '0;
            redir_pc_q    <= '0;
            redir_mask_q  <= '0;
            pend_warp_q   <= '0;
            pend_mask_q   <= '0;
            pend_pc_q     <= '0;
            pend_rpc_q    <= '0;
        end else begin
            state_q       <= state_d;
            if (init_go) begin
                sp_q[init_warp_num] <= SW'(1);
            end
            if (sp_we) begin
                sp_q[sp_warp] <= sp_val;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            redir_valid_q <= redir_valid_d;
            redir_warp_q  <= redir_warp_d;
            redir_pc_q    <= redir_pc_d;
            redir_mask_q  <= redir_mask_d;
            if (pend_we) begin
                pend_warp_q <= cmd_warp_num;
                pend_mask_q <= taken_t;
                pend_pc_q   <= cmd_taken_pc;
                pend_rpc_q  <= cmd_reconv_pc;
            end
        end
    end

    // Entry payload needs no reset: sp gates every read.
    always_ff @(posedge clk) begin
        if (init_go) begin
            mask_q[init_warp_num][0] <= init_mask;
            pc_q[init_warp_num][0]   <= init_pc;
            rpc_q[init_warp_num][0]  <= '1;
        end
        if (tpc_we) begin
            pc_q[cmd_warp_num][top_idx] <= tpc_val;
        end
        if (push_we) begin
            mask_q[push_warp][push_idx] <= push_mask;
            pc_q[push_warp][push_idx]   <= push_pc;
            rpc_q[push_warp][push_idx]  <= push_rpc;
        end
    end

endmodule

// File: tb/tb_gelato_split_table_ctrl.sv
// Bench for gelato_split_table_ctrl: directed scenarios plus random
// SPLIT/JOIN/INIT traffic against a stack-per-warp reference model.
module tb_gelato_split_table_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  lk_warp_num;
    logic [31:0] lk_thread_mask;
    logic [3:0]  lk_depth;
    logic        init_valid;
    logic [2:0]  init_warp_num;
    logic [31:0] init_pc;
    logic [31:0] init_mask;
    logic        init_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [2:0]  cmd_warp_num;
    logic [31:0] cmd_taken_mask;
    logic [31:0] cmd_taken_pc;
    logic [31:0] cmd_fall_pc;
    logic [31:0] cmd_reconv_pc;
    logic        redir_valid;
    logic [2:0]  redir_warp_num;
    logic [31:0] redir_pc;
    logic [31:0] redir_mask;
    logic        overflow_err;

    gelato_split_table_ctrl dut (
        .clk(clk), .rst(rst),
        .lk_warp_num(lk_warp_num), .lk_thread_mask(lk_thread_mask),
        .lk_depth(lk_depth),
        .init_valid(init_valid), .init_warp_num(init_warp_num),
        .init_pc(init_pc), .init_mask(init_mask), .init_ready(init_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_warp_num(cmd_warp_num), .cmd_taken_mask(cmd_taken_mask),
        .cmd_taken_pc(cmd_taken_pc), .cmd_fall_pc(cmd_fall_pc),
        .cmd_reconv_pc(cmd_reconv_pc),
        .redir_valid(redir_valid), .redir_warp_num(redir_warp_num),
        .redir_pc(redir_pc), .redir_mask(redir_mask),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] pc;
        logic [31:0] rpc;
    } ent_t;

    ent_t m_stk [8][8];
    int   m_sp  [8];
    bit   m_ovf;
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_sp[i] = 0;
        m_ovf = 1'b0;
    endtask

    task automatic m_init(int w, logic [31:0] msk, logic [31:0] pc);
        m_sp[w] = 1;
        m_stk[w][0] = {msk, pc, 32'hFFFF_FFFF};
    endtask

    task automatic m_cmd(input bit op, input int w, input logic [31:0] tm,
                         input logic [31:0] tpc, input logic [31:0] fpc,
                         input logic [31:0] rpc, output int lat,
                         output logic [31:0] epc, output logic [31:0] emask);
        int sp = m_sp[w];
        logic [31:0] top, t;
        lat = 0; epc = 0; emask = 0;
        if (sp == 0) return;
        top = m_stk[w][sp-1].mask;
        if (!op) begin
            t = tm & top;
            if (t == 0) begin
                m_stk[w][sp-1].pc = fpc;
                lat = 1; epc = fpc; emask = top;
            end else if (t == top) begin
                m_stk[w][sp-1].pc = tpc;
                lat = 1; epc = tpc; emask = top;
            end else if (sp + 2 > 8) begin
                m_ovf = 1'b1;
            end else begin
                m_stk[w][sp-1].pc = rpc;
                m_stk[w][sp]   = {top & ~t, fpc, rpc};
                m_stk[w][sp+1] = {t, tpc, rpc};
                m_sp[w] = sp + 2;
                lat = 2; epc = tpc; emask = t;
            end
        end else if (sp > 1 && fpc == m_stk[w][sp-1].rpc) begin
            m_sp[w] = sp - 1;
            lat = 1;
            epc = m_stk[w][sp-2].pc;
            emask = m_stk[w][sp-2].mask;
        end
    endtask

    task automatic chk_lk(int w);
        logic [31:0] em;
        lk_warp_num = 3'(w);
        #1;
        em = (m_sp[w] == 0) ? 32'h0 : m_stk[w][m_sp[w]-1].mask;
        chk("lk_depth", 64'(lk_depth), 64'(m_sp[w]));
        chk("lk_mask", 64'(lk_thread_mask), 64'(em));
    endtask

    task automatic do_init(int w, logic [31:0] msk, logic [31:0] pc);
        @(negedge clk);
        init_valid = 1'b1; init_warp_num = 3'(w);
        init_mask = msk; init_pc = pc;
        #1 chk("init_ready", 64'(init_ready), 64'd1);
        @(posedge clk);
        #1 init_valid = 1'b0;
        m_init(w, msk, pc);
        @(negedge clk);
        chk("init_no_redir", 64'(redir_valid), 64'd0);
        chk_lk(w);
    endtask

    task automatic do_cmd(bit op, int w, logic [31:0] tm, logic [31:0] tpc,
                          logic [31:0] fpc, logic [31:0] rpc);
        int lat, osp;
        logic [31:0] epc, emask;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_warp_num = 3'(w);
        cmd_taken_mask = tm; cmd_taken_pc = tpc;
        cmd_fall_pc = fpc; cmd_reconv_pc = rpc;
        #1 chk("cmd_ready", 64'(cmd_ready), 64'd1);
        osp = m_sp[w];
        m_cmd(op, w, tm, tpc, fpc, rpc, lat, epc, emask);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        if (lat == 2) begin
            chk("push2_ready", 64'(cmd_ready), 64'd0);
            chk("push2_redir", 64'(redir_valid), 64'd0);
            lk_warp_num = 3'(w);
            #1 chk("push2_depth", 64'(lk_depth), 64'(osp + 1));
            @(negedge clk);
        end
        chk("redir_valid", 64'(redir_valid), 64'(lat != 0));
        if (lat != 0) begin
            chk("redir_warp", 64'(redir_warp_num), 64'(w));
            chk("redir_pc", 64'(redir_pc), 64'(epc));
            chk("redir_mask", 64'(redir_mask), 64'(emask));
        end
        chk("overflow", 64'(overflow_err), 64'(m_ovf));
        chk_lk(w);
        @(negedge clk);
        chk("redir_pulse", 64'(redir_valid), 64'd0);
    endtask

    initial begin
        int w, r, c, lat;
        logic [31:0] tm, fpc, rpc, epc, emask;

        rst = 1'b1; lk_warp_num = '0;
        init_valid = 1'b0; init_warp_num = '0; init_pc = '0; init_mask = '0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_warp_num = '0;
        cmd_taken_mask = '0; cmd_taken_pc = '0;
        cmd_fall_pc = '0; cmd_reconv_pc = '0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_redir", 64'(redir_valid), 64'd0);
        chk("rst_init_ready", 64'(init_ready), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_ovf", 64'(overflow_err), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_lk(i);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic divergence and reconvergence on warp 3
        do_init(3, 32'hFFFF_FFFF, 32'h100);
        do_cmd(1'b0, 3, 32'h0000_FFFF, 32'h200, 32'h104, 32'h300);
        do_cmd(1'b1, 3, 32'h0, 32'h0, 32'h300, 32'h0);
        do_cmd(1'b1, 3, 32'h0, 32'h0, 32'h300, 32'h0);
        do_cmd(1'b1, 3, 32'h0, 32'h0, 32'h300, 32'h0);
        do_cmd(1'b0, 3, 32'hFFFF_FFFF, 32'h400, 32'h404, 32'h500);
        do_cmd(1'b0, 3, 32'h0, 32'h600, 32'h604, 32'h700);
        do_cmd(1'b0, 0, 32'h0000_00F0, 32'h10, 32'h14, 32'h18);

        // Nesting to overflow on warp 5
        do_init(5, 32'hFFFF_FFFF, 32'h1000);
        do_cmd(1'b0, 5, 32'h0000_FFFF, 32'h1100, 32'h1004, 32'h1200);
        do_cmd(1'b0, 5, 32'h0000_00FF, 32'h1300, 32'h1104, 32'h1400);
        do_cmd(1'b0, 5, 32'h0000_000F, 32'h1500, 32'h1304, 32'h1600);
        do_cmd(1'b0, 5, 32'h0000_0003, 32'h1700, 32'h1504, 32'h1800);
        do_cmd(1'b1, 5, 32'h0, 32'h0, 32'h1600, 32'h0);

        // Init and cmd in the same cycle: init wins, cmd is held
        @(negedge clk);
        init_valid = 1'b1; init_warp_num = 3'd6;
        init_mask = 32'h00FF_00FF; init_pc = 32'h2000;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_warp_num = 3'd6;
        cmd_taken_mask = 32'h0000_00FF; cmd_taken_pc = 32'h2100;
        cmd_fall_pc = 32'h2004; cmd_reconv_pc = 32'h2200;
        #1 chk("both_init_ready", 64'(init_ready), 64'd1);
        chk("both_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1 init_valid = 1'b0;
        m_init(6, 32'h00FF_00FF, 32'h2000);
        do_cmd(1'b0, 6, 32'h0000_00FF, 32'h2100, 32'h2004, 32'h2200);

        // Reset while a divergent split sits in PUSH2
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_warp_num = 3'd3;
        cmd_taken_mask = 32'h0000_000F; cmd_taken_pc = 32'h3100;
        cmd_fall_pc = 32'h3004; cmd_reconv_pc = 32'h3200;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_push2_ready", 64'(cmd_ready), 64'd0);
        rst = 1'b1;
        #1 chk("abort_redir_now", 64'(redir_valid), 64'd0);
        chk("abort_ovf_now", 64'(overflow_err), 64'd0);
        m_reset();
        @(negedge clk);
        chk("abort_redir", 64'(redir_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_lk(i);
        end
        rst = 1'b0;
        @(negedge clk);
        #1 chk("abort_idle", 64'(cmd_ready), 64'd1);
        chk("abort_redir_after", 64'(redir_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 8; i++) begin
            do_init(i, $urandom | 32'h1, 32'h8000 + 32'(i) * 32'h100);
        end
        for (int n = 0; n < 250; n++) begin
            w = $urandom_range(0, 7);
            r = $urandom_range(0, 99);
            rpc = 32'h9000 + 32'($urandom_range(0, 3)) * 4;
            if (r < 5) begin
                do_init(w, $urandom, $urandom);
            end else if (r < 55) begin
                c = $urandom_range(0, 3);
                tm = (c == 0) ? 32'h0 : (c == 1) ? 32'hFFFF_FFFF : $urandom;
                do_cmd(1'b0, w, tm, $urandom, $urandom, rpc);
            end else begin
                fpc = rpc;
                if (m_sp[w] > 0 && $urandom_range(0, 1) == 1)
                    fpc = m_stk[w][m_sp[w]-1].rpc;
                do_cmd(1'b1, w, $urandom, $urandom, fpc, $urandom);
            end
        end
        m_cmd(1'b1, 0, 32'h0, 32'h0, 32'h0, 32'h0, lat, epc, emask);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
